// File: rtl/board_evaluator_if.sv
`default_nettype none
// ============================================================================
//  Module      : board_evaluator_if
//  Description : Avalon-MM control slave and memory master bundle for the
//                board evaluator. The "slave" modport is the evaluator side,
//                the "master" modport is the host / memory side.
//  Revision    : 1.0  initial release
// ============================================================================
interface board_evaluator_if;
    // Control slave
    logic        slave_waitrequest;
    logic [3:0]  slave_address;
    logic        slave_read;
    logic [31:0] slave_readdata;
    logic        slave_write;
    logic [31:0] slave_writedata;
    // Memory master
    logic        master_waitrequest;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_write;
    logic [31:0] master_writedata;

    modport slave (
        output slave_waitrequest,
        input  slave_address,
        input  slave_read,
        output slave_readdata,
        input  slave_write,
        input  slave_writedata,
        input  master_waitrequest,
        output master_address,
        output master_read,
        input  master_readdata,
        input  master_readdatavalid,
        output master_write,
        output master_writedata
    );

    modport master (
        input  slave_waitrequest,
        output slave_address,
        output slave_read,
        input  slave_readdata,
        output slave_write,
        output slave_writedata,
        output master_waitrequest,
        input  master_address,
        input  master_read,
        output master_readdata,
        output master_readdatavalid,
        input  master_write,
        input  master_writedata
    );
endinterface
`default_nettype wire

// File: rtl/board_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : board_evaluator
//  Description : Reads N 64-byte boards from memory, computes a signed
//                material score (white minus black) per board and writes one
//                32-bit score word per board back to memory.
//  Revision    : 1.0  initial release
// ============================================================================
module board_evaluator #(
    parameter int MAX_BOARDS = 255,
    parameter int KING_VALUE = 20000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    board_evaluator_if.slave bus
);
    localparam logic [2:0] C_IDLE    = 3'd0;
    localparam logic [2:0] C_RD_REQ  = 3'd1;
    localparam logic [2:0] C_RD_WAIT = 3'd2;
    localparam logic [2:0] C_WR_REQ  = 3'd3;
    localparam logic [2:0] C_DONE    = 3'd4;

    localparam logic [7:0] C_MAX_COUNT = 8'(MAX_BOARDS);

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [31:0]        r_src;
    logic [31:0]        r_dst;
    logic [7:0]         r_count;
    logic [7:0]         r_done_cnt;
    logic [7:0]         r_board;
    logic [5:0]         r_sq;
    logic               r_error;
    logic signed [31:0] r_acc;
    logic [31:0]        r_last;

    logic               w_busy;
    logic               w_start;
    logic               w_last_board;
    logic [7:0]         w_code;
    logic [7:0]         w_mag;
    logic signed [31:0] w_wt;
    logic signed [31:0] w_delta;
    logic               w_bad;
    logic [31:0]        w_rd_addr;
    logic [31:0]        w_wr_addr;
    logic [31:0]        w_reg_rdata;
    logic               w_unused_ok;

    assign w_busy       = (r_state == C_RD_REQ) || (r_state == C_RD_WAIT) || (r_state == C_WR_REQ);
    assign w_start      = bus.slave_write && (bus.slave_address == 4'd0) && !w_busy;
    assign w_last_board = (({1'b0, r_board} + 9'd1) == {1'b0, r_count});
    // Byte address of the current square and word address of the current score
    assign w_rd_addr    = r_src + 32'({r_board, r_sq});
    assign w_wr_addr    = r_dst + 32'({r_board, 2'b00});
    // Only the low byte of memory read data carries a piece code
    assign w_unused_ok  = &{1'b0, bus.master_readdata[31:8]};

    // Piece code decode: magnitude selects the weight, sign selects the side
    always_comb begin
        w_code = bus.master_readdata[7:0];
        w_mag  = w_code[7] ? (8'd0 - w_code) : w_code;
        w_bad  = 1'b0;
        w_wt   = 32'sd0;
        if (w_mag == 8'd0)       w_wt = 32'sd0;
        else if (w_mag <= 8'd8)  w_wt = 32'sd100;
        else if (w_mag <= 8'd18) w_wt = 32'sd500;
        else if (w_mag <= 8'd28) w_wt = 32'sd320;
        else if (w_mag <= 8'd38) w_wt = 32'sd330;
        else if (w_mag <= 8'd47) w_wt = 32'sd900;
        else if (w_mag == 8'd48) w_wt = 32'(KING_VALUE);
        else                     w_bad = 1'b1;
        w_delta = w_code[7] ? (32'sd0 - w_wt) : w_wt;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= C_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_IDLE, C_DONE: begin
                if (w_start) w_next = (r_count == 8'd0) ? C_DONE : C_RD_REQ;
            end
            C_RD_REQ: begin
                if (!bus.master_waitrequest) w_next = C_RD_WAIT;
            end
            C_RD_WAIT: begin
                if (bus.master_readdatavalid) w_next = (r_sq == 6'd63) ? C_WR_REQ : C_RD_REQ;
            end
            C_WR_REQ: begin
                if (!bus.master_waitrequest) w_next = w_last_board ? C_DONE : C_RD_REQ;
            end
            default: w_next = C_IDLE;
        endcase
    end

    // Master strobes/address/data and slave handshake, decoded from state
    always_comb begin
        bus.master_read      = 1'b0;
        bus.master_write     = 1'b0;
        bus.master_address   = 32'd0;
        bus.master_writedata = 32'd0;
        case (r_state)
            C_RD_REQ: begin
                bus.master_read    = 1'b1;
                bus.master_address = w_rd_addr;
            end
            C_WR_REQ: begin
                bus.master_write     = 1'b1;
                bus.master_address   = w_wr_addr;
                bus.master_writedata = r_acc;
            end
            default: ;
        endcase
        bus.slave_waitrequest = w_busy && (bus.slave_read || bus.slave_write);
        bus.slave_readdata    = (bus.slave_read && !w_busy) ? w_reg_rdata : 32'd0;
    end

    // Register read multiplexer
    always_comb begin
        w_reg_rdata = 32'd0;
        case (bus.slave_address)
            4'd0:    w_reg_rdata = {r_error, 23'd0, r_done_cnt};
            4'd1:    w_reg_rdata = r_src;
            4'd2:    w_reg_rdata = r_dst;
            4'd3:    w_reg_rdata = {24'd0, r_count};
            4'd4:    w_reg_rdata = r_last;
            default: w_reg_rdata = 32'd0;
        endcase
    end

    // Configuration registers, accumulator and run counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src      <= 32'd0;
            r_dst      <= 32'd0;
            r_count    <= 8'd0;
            r_done_cnt <= 8'd0;
            r_board    <= 8'd0;
            r_sq       <= 6'd0;
            r_error    <= 1'b0;
            r_acc      <= 32'sd0;
            r_last     <= 32'd0;
        end else if (!w_busy) begin
            if (w_start) begin
                r_error    <= 1'b0;
                r_done_cnt <= 8'd0;
                r_acc      <= 32'sd0;
                r_board    <= 8'd0;
                r_sq       <= 6'd0;
            end else if (bus.slave_write) begin
                case (bus.slave_address)
                    4'd1: r_src <= bus.slave_writedata;
                    4'd2: r_dst <= bus.slave_writedata;
                    4'd3: r_count <= (bus.slave_writedata > 32'(MAX_BOARDS)) ?
                                     C_MAX_COUNT : bus.slave_writedata[7:0];
                    default: ;
                endcase
            end
        end else begin
            case (r_state)
                C_RD_WAIT: begin
                    if (bus.master_readdatavalid) begin
                        r_acc <= r_acc + w_delta;
                        r_sq  <= r_sq + 6'd1;
                        if (w_bad) r_error <= 1'b1;
                    end
                end
                C_WR_REQ: begin
                    if (!bus.master_waitrequest) begin
                        r_last     <= r_acc;
                        r_done_cnt <= r_done_cnt + 8'd1;
                        r_board    <= r_board + 8'd1;
                        r_acc      <= 32'sd0;
                        r_sq       <= 6'd0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_board_evaluator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_evaluator
//  Description : Self-checking bench for board_evaluator with a byte memory
//                responder and a material-score reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_board_evaluator;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    board_evaluator_if bus();

    board_evaluator #(.MAX_BOARDS(255), .KING_VALUE(20000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Memory image and responder bookkeeping
    logic [7:0]  mem [0:8191];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int          stall_mode = 0;      // 0 none, 1 random, 2 read #10 and writes
    int          stall_rd_target = -1;
    int          rd_num = 0;
    int          traffic = 0;
    int          stab_bad = 0;
    int          spur_req = 0;
    int          spur_done = 0;
    bit          in_req = 0;
    bit          req_is_rd = 0;
    logic [31:0] req_addr = 0;
    logic [31:0] req_wd = 0;
    int          stall_left = 0;
    bit          pending = 0;
    logic [31:0] pend_addr = 0;

    // Memory responder: decides waitrequest and read data on the falling edge
    always @(negedge clk) begin
        logic [31:0] t;
        if (!rst_n) begin
            pending = 0; in_req = 0;
            bus.master_readdatavalid = 1'b0;
            bus.master_waitrequest   = 1'b0;
            bus.master_readdata      = 32'd0;
        end else begin
            t = $urandom;
            if (pending) begin
                t[7:0] = mem[pend_addr[12:0]];
                bus.master_readdatavalid = 1'b1;
                pending = 0;
            end else if (spur_req != spur_done && !bus.master_read) begin
                t[7:0] = 8'd39;
                bus.master_readdatavalid = 1'b1;
                spur_done++;
            end else begin
                bus.master_readdatavalid = 1'b0;
            end
            bus.master_readdata = t;
            if (bus.master_read || bus.master_write) begin
                traffic++;
                if (!in_req) begin
                    in_req = 1; req_is_rd = bus.master_read;
                    req_addr = bus.master_address; req_wd = bus.master_writedata;
                    if (bus.master_read) rd_num++;
                    case (stall_mode)
                        1:       stall_left = $urandom_range(0, 2);
                        2:       stall_left = (!bus.master_read || rd_num == stall_rd_target) ? 3 : 0;
                        default: stall_left = 0;
                    endcase
                end else if (bus.master_address !== req_addr || bus.master_read !== req_is_rd ||
                             (bus.master_write && bus.master_writedata !== req_wd)) begin
                    stab_bad++;
                end
                if (stall_left > 0) begin
                    bus.master_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    bus.master_waitrequest = 1'b0;
                    in_req = 0;
                    if (bus.master_read) begin
                        pending = 1; pend_addr = bus.master_address;
                    end else begin
                        wr_addr_q.push_back(bus.master_address);
                        wr_data_q.push_back(bus.master_writedata);
                    end
                end
            end else begin
                in_req = 0;
                bus.master_waitrequest = (stall_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Material score of one board straight from the piece-value table
    function automatic int model_score(input int base, output bit bad);
        int s = 0;
        bad = 0;
        for (int q = 0; q < 64; q++) begin
            int c, m, w;
            c = int'($signed(mem[(base + q) % 8192]));
            m = (c < 0) ? -c : c;
            if (m == 0)       w = 0;
            else if (m <= 8)  w = 100;
            else if (m <= 18) w = 500;
            else if (m <= 28) w = 320;
            else if (m <= 38) w = 330;
            else if (m <= 47) w = 900;
            else if (m == 48) w = 20000;
            else begin w = 0; bad = 1; end
            s += (c < 0) ? -w : w;
        end
        return s;
    endfunction

    task automatic clear_board(input int base);
        for (int q = 0; q < 64; q++) mem[(base + q) % 8192] = 8'd0;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        bus.slave_address = a; bus.slave_writedata = d; bus.slave_write = 1'b1;
        #1;
        while (bus.slave_waitrequest && n < 5000) begin @(negedge clk); #1; n++; end
        if (n >= 5000) check("write_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus.slave_write = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, input int limit, output logic [31:0] d, output int n);
        n = 0;
        @(negedge clk);
        bus.slave_address = a; bus.slave_read = 1'b1;
        #1;
        while (bus.slave_waitrequest && n < limit) begin @(negedge clk); #1; n++; end
        d = bus.slave_readdata;
        @(posedge clk); #1;
        bus.slave_read = 1'b0;
    endtask

    // Configure, start, wait on status, then compare writes and registers to the model
    task automatic run(input logic [31:0] src, input logic [31:0] dst, input int cnt, output int wb);
        logic [31:0] st, r4;
        int cyc, lim, exp_last;
        bit err, bad;
        wb = wr_addr_q.size();
        err = 0; exp_last = 0;
        lim = cnt * 400 + 200;
        reg_write(4'd1, src); reg_write(4'd2, dst); reg_write(4'd3, 32'(cnt));
        reg_write(4'd0, 32'd0);
        reg_read(4'd0, lim, st, cyc);
        check("done_timeout", 32'(cyc < lim), 32'd1);
        for (int b = 0; b < cnt; b++) begin
            int e;
            e = model_score(int'(src) + 64 * b, bad);
            err |= bad;
            exp_last = e;
            if (wb + b < wr_data_q.size()) begin
                check("wr_addr", wr_addr_q[wb + b], dst + 32'(4 * b));
                check("wr_score", wr_data_q[wb + b], 32'(e));
            end
        end
        check("wr_count", 32'(wr_addr_q.size() - wb), 32'(cnt));
        check("status", st, {err, 23'd0, 8'(cnt)});
        reg_read(4'd4, 10, r4, cyc);
        if (cnt > 0) check("last_score", r4, 32'(exp_last));
        check("stable_while_stalled", 32'(stab_bad), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int n, wb, tr;
        bus.slave_address = 4'd0; bus.slave_read = 1'b0;
        bus.slave_write = 1'b0; bus.slave_writedata = 32'd0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mread", 32'(bus.master_read), 32'd0);
        check("rst_mwrite", 32'(bus.master_write), 32'd0);
        check("rst_maddr", bus.master_address, 32'd0);
        check("rst_swait", 32'(bus.slave_waitrequest), 32'd0);
        rst_n = 1'b1;
        for (int r = 0; r < 5; r++) begin
            reg_read(4'(r), 10, d, n);
            check("rst_reg", d, 32'd0);
        end

        // Standard opening board
        begin
            logic [7:0] back [8];
            back[0] = 8'd9;  back[1] = 8'd19; back[2] = 8'd29; back[3] = 8'd39;
            back[4] = 8'd48; back[5] = 8'd30; back[6] = 8'd20; back[7] = 8'd10;
            clear_board(0);
            for (int f = 0; f < 8; f++) begin
                mem[f]      = back[f];
                mem[8 + f]  = 8'(f + 1);
                mem[48 + f] = 8'd0 - 8'(f + 1);
                mem[56 + f] = 8'd0 - back[f];
            end
        end
        run(32'd0, 32'h200, 1, wb);
        check("opening_score", wr_data_q[wb], 32'd0);

        // Queen against a black pawn
        clear_board(0); mem[0] = 8'd39; mem[63] = 8'hFF;
        run(32'd0, 32'h300, 1, wb);
        check("queen_pawn", wr_data_q[wb], 32'd800);

        // Three boards with stalls on read 10 and on every write
        clear_board(0); clear_board(64); clear_board(128);
        mem[20] = 8'd39; mem[64 + 33] = 8'hF7;
        stall_mode = 2; stall_rd_target = rd_num + 10;
        run(32'd0, 32'h1000, 3, wb);
        stall_mode = 0;
        check("three_b1", wr_data_q[wb + 1], 32'hFFFF_FE0C);

        // Invalid code sets the sticky error, a clean run clears it
        clear_board(0); mem[5] = 8'h40; mem[6] = 8'd29;
        run(32'd0, 32'h400, 1, wb);
        check("err_score", wr_data_q[wb], 32'd330);
        clear_board(0); mem[9] = 8'd29;
        run(32'd0, 32'h400, 1, wb);

        // Count zero: no master traffic, status available at once
        tr = traffic;
        reg_write(4'd3, 32'd0); reg_write(4'd0, 32'd0);
        reg_read(4'd0, 2, d, n);
        check("cnt0_status", d, 32'd0);
        check("cnt0_latency", 32'(n <= 2), 32'd1);
        check("cnt0_traffic", 32'(traffic - tr), 32'd0);

        // Stray readdatavalid while idle is ignored
        clear_board(0); mem[40] = 8'hD1;   // black queen
        spur_req++;
        repeat (4) @(negedge clk);
        run(32'd0, 32'h500, 1, wb);

        // Register map corners: clamp, unused addresses
        reg_write(4'd3, 32'd300);
        reg_read(4'd3, 10, d, n);  check("clamp_300", d, 32'd255);
        reg_write(4'd3, 32'd256);
        reg_read(4'd3, 10, d, n);  check("clamp_256", d, 32'd255);
        reg_write(4'd1, 32'h1234);
        reg_write(4'd9, 32'hDEAD);
        reg_read(4'd9, 10, d, n);  check("unmapped_read", d, 32'd0);
        reg_read(4'd1, 10, d, n);  check("src_kept", d, 32'h1234);

        // Randomised boards with random memory stalls
        stall_mode = 1;
        for (int k = 0; k < 4; k++) begin
            int cnt, src;
            cnt = $urandom_range(1, 3);
            src = $urandom_range(0, 3000);
            for (int q = 0; q < 64 * cnt; q++) begin
                int r, m;
                r = $urandom_range(0, 99);
                if (r < 40)      m = 0;
                else if (r < 95) m = $urandom_range(1, 48);
                else             m = $urandom_range(49, 128);
                if (m == 128) mem[(src + q) % 8192] = 8'h80;
                else mem[(src + q) % 8192] = ($urandom_range(0, 1) != 0) ? 8'd0 - 8'(m) : 8'(m);
            end
            run(32'(src), 32'($urandom_range(0, 16383)) * 4, cnt, wb);
        end
        stall_mode = 0;

        // Asynchronous reset in the middle of a board
        clear_board(0); mem[2] = 8'd48;
        reg_write(4'd1, 32'd0); reg_write(4'd2, 32'h600); reg_write(4'd3, 32'd2);
        reg_write(4'd0, 32'd0);
        repeat (100) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mread", 32'(bus.master_read), 32'd0);
        check("arst_mwrite", 32'(bus.master_write), 32'd0);
        check("arst_maddr", bus.master_address, 32'd0);
        check("arst_mwdata", bus.master_writedata, 32'd0);
        check("arst_swait", 32'(bus.slave_waitrequest), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tr = traffic;
        repeat (40) @(negedge clk);
        check("arst_no_traffic", 32'(traffic - tr), 32'd0);
        for (int r = 0; r < 5; r++) begin
            reg_read(4'(r), 2, d, n);
            check("arst_reg", d, 32'd0);
            check("arst_idle", 32'(n), 32'd0);
        end
        run(32'd0, 32'h700, 1, wb);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
